conv_result_collector: RTL and testbench

//  Receiving end of the Conv output stream (dout/out_st). Captures one 6x6 frame of 16-bit

---
 rtl/conv_pkg.sv | 14 +
 rtl/conv_result_ram.sv | 31 +++
 rtl/conv_result_collector.sv | 106 ++++++++++
 tb/tb_conv_result_collector.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared parameters and collector state encoding for the Conv result collector.
package conv_pkg;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned OUT_ROWS  = 6;
  localparam int unsigned OUT_COLS  = 6;
  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned N_RESULTS = OUT_ROWS * OUT_COLS;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FULL
  } coll_state_e;
endpackage

// File: rtl/conv_result_ram.sv
// Result RAM: one write port, one registered read port returning old data on collision.
module conv_result_ram
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);
  logic [DATA_W-1:0] mem [N_RESULTS];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Out-of-range indices read as zero rather than aliasing into the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= (rd_addr < ADDR_W'(N_RESULTS)) ? mem[rd_addr] : '0;
    end
  end
endmodule

// File: rtl/conv_result_collector.sv
// Captures one frame of Conv results in raster order and serves them on a read port.
// Optional CONV_MAX_TRACK_EN adds a running unsigned maximum (max_val/max_idx).
module conv_result_collector
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_in,
  input  logic [DATA_W-1:0] din,
  input  logic              clr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] wr_count,
  output logic              frame_done,
  output logic              full,
  output logic              overflow
`ifdef CONV_MAX_TRACK_EN
  ,
  output logic [DATA_W-1:0] max_val,
  output logic [ADDR_W-1:0] max_idx
`endif
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_RESULTS - 1);

  coll_state_e       state, state_d;
  logic [ADDR_W-1:0] wr_ptr;
  logic              we;

  always_comb begin
    state_d = state;
    we      = 1'b0;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (st_in) begin
            we      = 1'b1;
            state_d = COLLECT;
          end
        end
        COLLECT: begin
          if (st_in) begin
            we = 1'b1;
            if (wr_ptr == LAST) state_d = FULL;
          end
        end
        default: ;
      endcase
    end
  end

  // Pointer parks at LAST on the final write so wr_count saturates while full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state <= state_d;
      if (clr) begin
        wr_ptr     <= '0;
        frame_done <= 1'b0;
        overflow   <= 1'b0;
      end else begin
        frame_done <= we && (wr_ptr == LAST);
        if (we && (wr_ptr != LAST)) wr_ptr <= wr_ptr + 1'b1;
        if ((state == FULL) && st_in) overflow <= 1'b1;
      end
    end
  end

  assign full     = (state == FULL);
  assign wr_count = wr_ptr;

`ifdef CONV_MAX_TRACK_EN
  // Strict compare keeps the earliest index on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_val <= '0;
      max_idx <= '0;
    end else if (clr) begin
      max_val <= '0;
      max_idx <= '0;
    end else if (we && (din > max_val)) begin
      max_val <= din;
      max_idx <= wr_ptr;
    end
  end
`endif

  conv_result_ram u_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .wr_addr  (wr_ptr),
    .wr_data  (din),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );
endmodule

// File: tb/tb_conv_result_collector.sv
// Scoreboard bench for conv_result_collector: frame capture, flags, reads, reset, overflow.
module tb_conv_result_collector;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_in = 1'b0;
  logic [15:0] din = '0;
  logic        clr = 1'b0;
  logic        rd_en = 1'b0;
  logic [5:0]  rd_addr = '0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [5:0]  wr_count;
  logic        frame_done;
  logic        full;
  logic        overflow;
`ifdef CONV_MAX_TRACK_EN
  logic [15:0] max_val;
  logic [5:0]  max_idx;
`endif

  conv_result_collector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .st_in      (st_in),
    .din        (din),
    .clr        (clr),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .wr_count   (wr_count),
    .frame_done (frame_done),
    .full       (full),
    .overflow   (overflow)
`ifdef CONV_MAX_TRACK_EN
    ,
    .max_val    (max_val),
    .max_idx    (max_idx)
`endif
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mref [36];
  int          cnt = 0;
  bit          ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Read-data monitor: every rd_valid must match the oldest outstanding read.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rd_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rd_unexpected: rd_valid=1 data=%0h with no read pending", rd_data);
        end else begin
          chk("rd_data", {16'h0, rd_data}, {16'h0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic step(input bit s, input logic [15:0] d, input bit c, input bit re,
                      input logic [5:0] ra);
    bit exp_done;
    st_in = s; din = d; clr = c; rd_en = re; rd_addr = ra;
    if (re) exp_q.push_back((ra < 6'd36) ? mref[ra] : 16'h0000);
    exp_done = 1'b0;
    if (c) begin
      cnt = 0;
      ovf = 1'b0;
    end else if (s) begin
      if (cnt == 36) ovf = 1'b1;
      else begin
        mref[cnt] = d;
        cnt++;
        exp_done = (cnt == 36);
      end
    end
    @(posedge clk); #1;
    st_in = 1'b0; clr = 1'b0; rd_en = 1'b0;
    chk("frame_done", {31'h0, frame_done}, {31'h0, exp_done});
    chk("full", {31'h0, full}, {31'h0, (cnt == 36)});
    chk("overflow", {31'h0, overflow}, {31'h0, ovf});
    chk("wr_count", {26'h0, wr_count}, (cnt == 36) ? 32'd35 : cnt);
`ifdef CONV_MAX_TRACK_EN
    begin
      logic [15:0] mv;
      int mi;
      mv = 16'h0; mi = 0;
      for (int i = 0; i < cnt; i++) if (mref[i] > mv) begin mv = mref[i]; mi = i; end
      chk("max_val", {16'h0, max_val}, {16'h0, mv});
      chk("max_idx", {26'h0, max_idx}, mi);
    end
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 6'd0);
  endtask

  task automatic read_all;
    for (int i = 0; i < 36; i++) step(1'b0, 16'h0, 1'b0, 1'b1, 6'(i));
  endtask

  task automatic do_reset;
    @(negedge clk); #1;
    rst_n = 1'b0;
    cnt = 0;
    ovf = 1'b0;
    #12;
    chk("rst_rd_data", {16'h0, rd_data}, 32'h0);
    chk("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
    chk("rst_wr_count", {26'h0, wr_count}, 32'h0);
    chk("rst_frame_done", {31'h0, frame_done}, 32'h0);
    chk("rst_full", {31'h0, full}, 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 36; i++) mref[i] = 16'h0;
    do_reset();

    // Back-to-back frame with ramp data
    for (int i = 0; i < 36; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, 6'd0);
    idle(2);
    read_all();
    idle(2);

    // Gapped strobes, random interleaved reads of settled addresses
    step(1'b0, 16'h0, 1'b1, 1'b0, 6'd0);
    for (int i = 0; i < 36; i++) begin
      int g;
      g = $urandom_range(1, 3);
      for (int k = 0; k < g; k++) step(1'b0, 16'h0, 1'b0, 1'b1, 6'($urandom_range(0, 35)));
      step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, 6'd0);
    end
    read_all();

    // Overflow on a full frame, then clr
    step(1'b1, 16'hFFFF, 1'b0, 1'b0, 6'd0);
    step(1'b1, 16'hFFFF, 1'b0, 1'b1, 6'd0);
    step(1'b0, 16'h0, 1'b0, 1'b1, 6'd0);
    step(1'b0, 16'h0, 1'b1, 1'b0, 6'd0);
    idle(1);

    // Out-of-range read and read/write collision at address 5
    step(1'b0, 16'h0, 1'b0, 1'b1, 6'd40);
    step(1'b0, 16'h0, 1'b0, 1'b1, 6'd63);
    for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 6'd0);
    step(1'b1, 16'hBEEF, 1'b0, 1'b1, 6'd5);
    step(1'b0, 16'h0, 1'b0, 1'b1, 6'd5);

    // clr and strobe together: sample dropped
    step(1'b1, 16'h1234, 1'b1, 1'b0, 6'd0);
    step(1'b1, 16'h4321, 1'b0, 1'b0, 6'd0);
    step(1'b0, 16'h0, 1'b0, 1'b1, 6'd0);

    // Reset mid-frame, then a full random frame
    for (int i = 0; i < 9; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 6'd0);
    idle(1);
    do_reset();
    for (int i = 0; i < 36; i++) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, 16'h0, 1'b0, 1'b0, 6'd0);
      step(1'b1, 16'($urandom), 1'b0, 1'b0, 6'd0);
    end
    read_all();

    // Max tracking with a tie at indices 7 and 20
    step(1'b0, 16'h0, 1'b1, 1'b0, 6'd0);
    for (int i = 0; i < 36; i++)
      step(1'b1, (i == 7 || i == 20) ? 16'h0A55 : 16'($urandom_range(0, 16'h0A54)),
           1'b0, $urandom_range(0, 1) == 1, 6'($urandom_range(0, 50)));
    step(1'b0, 16'h0, 1'b1, 1'b0, 6'd0);
    idle(3);

    chk("scoreboard_drain", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
